// File: rtl/calculator_pkg.sv
// calculator_pkg: shared widths and the result-drain state type and FIFO depth
package calculator_pkg;
    localparam int ADDR_W = 9;
    localparam int MEM_WORD_SIZE = 64;
    localparam int DRAIN_FIFO_DEPTH = 4;
    typedef enum logic [1:0] {DR_IDLE, DR_READ, DR_DRAIN, DR_DONE} drain_state_t;
endpackage

// File: rtl/drain_fifo.sv
// drain_fifo: synchronous FIFO (WIDTH x DEPTH) buffering words read back from the result SRAMs
//  clk_i, rst_i : clock, synchronous active-high reset (flushes contents)
//  push, din    : write din when push
//  pop, dout    : dout is the head word; pop removes it
//  full, empty  : occupancy flags
//  count        : number of stored words (0..DEPTH)
module drain_fifo
    import calculator_pkg::*;
#(
    parameter int DEPTH = DRAIN_FIFO_DEPTH,
    parameter int WIDTH = MEM_WORD_SIZE,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
)(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    // a push into a full FIFO is accepted only when the head leaves in the same cycle
    assign do_push = push && (!full || pop);
    assign do_pop = pop && !empty;
    assign full = count == CW'(DEPTH);
    assign empty = count == '0;
    assign dout = mem[rd_ptr];
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= din;
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/result_drain.sv
// result_drain: reads an inclusive SRAM address range and streams the words over valid/ready
//  clk_i, rst_i              : clock, synchronous active-high reset
//  start_i                   : pulse to latch start_addr_i/end_addr_i and begin (ignored unless idle)
//  read_o, r_addr_o          : SRAM port-1 read enable and address
//  r_data_i                  : SRAM read data, valid the cycle after read_o
//  data_o, valid_o, ready_i  : output stream, transfer on valid_o & ready_i
//  busy_o                    : range in progress
//  done_o                    : one-cycle pulse after the final word is accepted
//  last_o                    : final word of the range (only with RESULT_DRAIN_LAST_EN defined)
module result_drain
    import calculator_pkg::*;
#(
    parameter int FIFO_DEPTH = DRAIN_FIFO_DEPTH
)(
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic [ADDR_W-1:0]        start_addr_i,
    input  logic [ADDR_W-1:0]        end_addr_i,
    output logic                     read_o,
    output logic [ADDR_W-1:0]        r_addr_o,
    input  logic [MEM_WORD_SIZE-1:0] r_data_i,
    output logic [MEM_WORD_SIZE-1:0] data_o,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic                     busy_o,
    output logic                     done_o
`ifdef RESULT_DRAIN_LAST_EN
    ,output logic                    last_o
`endif
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    drain_state_t state, state_nx;
    logic [ADDR_W-1:0] addr, remain;
    logic inflight, pop, empty, full, credit;
    logic [CW-1:0] count;
    logic [MEM_WORD_SIZE-1:0] head;
    drain_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(MEM_WORD_SIZE)) u_fifo (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .push(inflight),
        .din(r_data_i),
        .pop(pop),
        .dout(head),
        .full(full),
        .empty(empty),
        .count(count)
    );
    // count + inflight never exceeds FIFO_DEPTH, so a same-cycle pop always frees a slot and
    // otherwise a slot is free unless the FIFO is full or one short with a word still in flight
    assign credit = pop || !(full || (count == CW'(FIFO_DEPTH - 1) && inflight));
    assign r_addr_o = addr;
    always_ff @(posedge clk_i) begin
        if (rst_i) state <= DR_IDLE;
        else state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        case (state)
            DR_IDLE: state_nx = start_i ? DR_READ : DR_IDLE;
            DR_READ: state_nx = (read_o && remain == '0) ? DR_DRAIN : DR_READ;
            DR_DRAIN: state_nx = (empty && !inflight) ? DR_DONE : DR_DRAIN;
            default: state_nx = DR_IDLE;
        endcase
    end
    always_comb begin
        read_o = (state == DR_READ) && credit;
        busy_o = (state == DR_READ) || (state == DR_DRAIN);
        done_o = state == DR_DONE;
        valid_o = !empty;
        data_o = valid_o ? head : '0;
        pop = valid_o && ready_i;
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr <= '0;
            remain <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= read_o;
            if (state == DR_IDLE && start_i) begin
                addr <= start_addr_i;
                remain <= end_addr_i - start_addr_i;
            end else if (read_o) begin
                addr <= addr + 1'b1;
                remain <= remain - 1'b1;
            end
        end
    end
`ifdef RESULT_DRAIN_LAST_EN
    // words still to be accepted after the current head; zero marks the head as the final word
    logic [ADDR_W-1:0] left;
    always_ff @(posedge clk_i) begin
        if (rst_i) left <= '0;
        else if (state == DR_IDLE && start_i) left <= end_addr_i - start_addr_i;
        else if (pop) left <= left - 1'b1;
    end
    assign last_o = valid_o && left == '0;
`endif
endmodule

// File: tb/tb_result_drain.sv
// tb_result_drain: self-checking bench for result_drain with a behavioural SRAM holding {a+0x100, a}
module tb_result_drain;
    import calculator_pkg::*;
    logic clk = 0;
    logic rst_i = 1, start_i = 0, ready_i = 1;
    logic [8:0] start_addr_i = '0, end_addr_i = '0, r_addr_o;
    logic [63:0] r_data_i = '0, data_o;
    logic read_o, valid_o, busy_o, done_o;
`ifdef RESULT_DRAIN_LAST_EN
    logic last_o;
`endif

    result_drain dut (
        .clk_i(clk),
        .rst_i(rst_i),
        .start_i(start_i),
        .start_addr_i(start_addr_i),
        .end_addr_i(end_addr_i),
        .read_o(read_o),
        .r_addr_o(r_addr_o),
        .r_data_i(r_data_i),
        .data_o(data_o),
        .valid_o(valid_o),
        .ready_i(ready_i),
        .busy_o(busy_o),
        .done_o(done_o)
`ifdef RESULT_DRAIN_LAST_EN
        ,.last_o(last_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [8:0]  s;
        logic [8:0]  e;
        int          pct;
        int          n;
        logic [63:0] first;
        logic [63:0] last;
    } vec_t;

    int passed = 0, total = 0, ready_pct = 100;
    int done_cnt = 0, stall_err = 0, credit_err = 0, issued = 0, accepted = 0;
    bit prev_stall = 0;
    logic [63:0] prev_data = '0;
    logic [63:0] got[$];
    logic [8:0] addrq[$];
    bit lastq[$];

    function automatic logic [63:0] word(input logic [8:0] a);
        return {32'(a) + 32'h100, 32'(a)};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    always @(posedge clk) if (read_o) r_data_i <= word(r_addr_o);

    always @(posedge clk) begin
        #1;
        ready_i = int'($urandom_range(0, 99)) < ready_pct;
    end

    always @(negedge clk) begin
        if (read_o && (issued - accepted - int'(valid_o && ready_i)) >= DRAIN_FIFO_DEPTH) credit_err++;
        if (read_o) begin
            issued++;
            addrq.push_back(r_addr_o);
        end
        if (prev_stall && (!valid_o || data_o !== prev_data)) stall_err++;
        prev_stall = valid_o && !ready_i;
        prev_data = data_o;
        if (valid_o && ready_i) begin
            accepted++;
            got.push_back(data_o);
`ifdef RESULT_DRAIN_LAST_EN
            lastq.push_back(last_o);
`endif
        end
        if (done_o) done_cnt++;
    end

    task automatic pulse(input logic [8:0] s, input logic [8:0] e);
        @(posedge clk);
        #2 start_i = 1; start_addr_i = s; end_addr_i = e;
        @(posedge clk);
        #2 start_i = 0;
    endtask

    task automatic clear();
        got.delete();
        addrq.delete();
        lastq.delete();
        done_cnt = 0;
    endtask

    task automatic kick(input logic [8:0] s, input logic [8:0] e);
        clear();
        pulse(s, e);
    endtask

    task automatic finish(input string tag, input logic [8:0] s, input int n,
                          input logic [63:0] first, input logic [63:0] last);
        int bad;
        int lasts;
        bad = 0;
        lasts = 0;
        for (int i = 0; i < 5000 && done_cnt == 0; i++) @(posedge clk);
        chk({tag, "_done_seen"}, done_cnt != 0, 1);
        repeat (4) @(posedge clk);
        chk({tag, "_count"}, got.size(), n);
        chk({tag, "_first"}, got.size() > 0 ? got[0] : 64'd0, first);
        chk({tag, "_last"}, got.size() > 0 ? got[got.size() - 1] : 64'd0, last);
        if (addrq.size() != n) bad++;
        for (int i = 0; i < got.size(); i++) if (got[i] !== word(s + 9'(i))) bad++;
        for (int i = 0; i < addrq.size(); i++) if (addrq[i] !== s + 9'(i)) bad++;
        chk({tag, "_order"}, bad, 0);
        chk({tag, "_done_once"}, done_cnt, 1);
`ifdef RESULT_DRAIN_LAST_EN
        foreach (lastq[i]) if (lastq[i]) lasts++;
        chk({tag, "_last_o"}, lasts == 1 && lastq.size() > 0 && lastq[lastq.size() - 1], 1);
`endif
    endtask

    vec_t vecs[5];

    initial begin
        vecs[0] = '{9'h010, 9'h013, 100, 4,  64'h00000110_00000010, 64'h00000113_00000013};
        vecs[1] = '{9'h1FF, 9'h1FF, 100, 1,  64'h000002FF_000001FF, 64'h000002FF_000001FF};
        vecs[2] = '{9'h1FE, 9'h001, 100, 4,  64'h000002FE_000001FE, 64'h00000101_00000001};
        vecs[3] = '{9'h000, 9'h00F, 30,  16, 64'h00000100_00000000, 64'h0000010F_0000000F};
        vecs[4] = '{9'h100, 9'h13F, 70,  64, 64'h00000200_00000100, 64'h0000023F_0000013F};

        repeat (3) @(posedge clk);
        #2 rst_i = 0;
        @(negedge clk);
        chk("reset_ctrl", {read_o, valid_o, busy_o, done_o}, 0);
        chk("reset_data", data_o, 0);
        chk("reset_addr", r_addr_o, 0);

        // start latency: read at N+1, first valid word at N+3
        clear();
        @(posedge clk);
        #2 start_i = 1; start_addr_i = 9'h010; end_addr_i = 9'h013;
        @(posedge clk);
        #2 start_i = 0;
        @(negedge clk);
        chk("lat_read_busy", {read_o, busy_o}, 2'b11);
        chk("lat_addr", r_addr_o, 9'h010);
        chk("lat_valid_c1", valid_o, 0);
        @(negedge clk);
        chk("lat_valid_c2", valid_o, 0);
        @(negedge clk);
        chk("lat_valid_c3", valid_o, 1);
        chk("lat_data", data_o, 64'h00000110_00000010);
        finish("lat", 9'h010, 4, 64'h00000110_00000010, 64'h00000113_00000013);

        for (int i = 0; i < 5; i++) begin
            ready_pct = vecs[i].pct;
            kick(vecs[i].s, vecs[i].e);
            finish($sformatf("vec%0d", i), vecs[i].s, vecs[i].n, vecs[i].first, vecs[i].last);
        end

        // reset in the middle of a range
        ready_pct = 100;
        kick(9'h000, 9'h00F);
        for (int i = 0; i < 200 && got.size() < 5; i++) @(posedge clk);
        chk("rst_mid_reached", got.size() >= 5, 1);
        @(posedge clk);
        #2 rst_i = 1;
        @(posedge clk);
        #2 rst_i = 0;
        issued = 0;
        accepted = 0;
        prev_stall = 0;
        got.delete();
        @(negedge clk);
        chk("rst_mid_ctrl", {read_o, valid_o, busy_o, done_o}, 0);
        chk("rst_mid_data", data_o, 0);
        repeat (4) @(posedge clk);
        chk("rst_mid_no_done", done_cnt, 0);
        chk("rst_mid_no_stale", got.size(), 0);
        kick(9'h020, 9'h021);
        finish("restart", 9'h020, 2, 64'h00000120_00000020, 64'h00000121_00000021);

        // second start while busy is ignored
        kick(9'h030, 9'h037);
        repeat (2) @(posedge clk);
        #2 chk("busy_before_restart", busy_o, 1);
        pulse(9'h100, 9'h105);
        finish("ignore", 9'h030, 8, 64'h00000130_00000030, 64'h00000137_00000037);

        chk("stall_stable", stall_err, 0);
        chk("credit_rule", credit_err, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
